decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode stage of the 5-stage ARM pipeline; sits directly after fetch and is the consumer of the fetch stage's valid/inst/pc outputs.
- Decodes data-processing, LDR/STR and B/BL into a registered ID/EX bundle.
- Detects load-use hazards and drives the stall request back to fetch.
- Honors the branch-resolve flush from execute.

Parameters:
- NOP_ON_NV, 1, when 1 a cond field of 4'hF decodes as a bubble; when 0 it decodes as "always".

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_n_i  input  1  synchronous, active-low reset
- valid_i  input  1  fetch output valid
- inst_i  input  32  fetched instruction
- pc_i  input  32  address of inst_i
- flush_i  input  1  branch/PC-write taken in execute; kill the instruction in decode
- stall_o  output  1  combinational; fetch holds its PC and inst_i this cycle
- valid_o  output  1  ID/EX bundle valid
- pc_o  output  32  registered pc_i
- cond_o  output  4  inst[31:28]
- opcode_o  output  4  inst[24:21] for data-processing, else 0
- set_flags_o  output  1  inst[20] for data-processing, else 0
- rn_o, rd_o, rm_o  output  4 each  register specifiers; rd_o=14 for BL
- imm_o  output  32  decoded immediate
- use_imm_o  output  1  operand 2 is imm_o
- is_load_o, is_store_o, is_branch_o, is_link_o  output  1 each  class flags
- reg_write_o  output  1  instruction writes rd_o
- pc_write_o  output  1  reg_write_o && rd_o==15
- branch_target_o  output  32  pc_i + 8 + {{6{inst[23]}}, inst[23:0], 2'b00}, mod 2^32

Behaviour:
- Interface: one clock, clk_i; reset_n_i is synchronous and active-low.
- Reset: while reset_n_i==0 at a rising edge, every registered output clears to 0. stall_o is 0 while in reset.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Class decode on inst[27:26]:
  - 00 is data-processing. use_imm_o=inst[25]. imm_o holds the 8-bit immediate, or 0 for register operand2.
  - 01 is load/store. The L bit inst[20] selects load or store. use_imm_o=~inst[25]. imm_o={20'b0, inst[11:0]}.
  - 10 with inst[25]==1 is a branch. is_link_o=inst[24].
  - 10 with inst[25]==0, and 11, decode as a bubble.
- reg_write_o is 1 for:
  - data-processing ops other than TST/TEQ/CMP/CMN (opcodes 8–11)
  - loads
  - BL
- Sources read by the incoming instruction:
  - data-processing: rn (unless MOV/MVN, opcodes 13/15), plus rm when inst[25]==0
  - load/store: rn, plus rm when inst[25]==1
  - store: additionally rd, the data register
  - branch: no sources
- Load-use hazard: stall_o=1 when all of the following hold:
  - valid_i && valid_o && is_load_o && !flush_i
  - the incoming instruction reads register rd_o
- While stall_o==1, the output register loads a bubble (valid_o=0 next cycle, all other outputs unchanged) and inst_i/pc_i are not consumed.
- A stall therefore lasts exactly 1 cycle: the bubble removes the hazard on the following cycle.
- Flush:
  - flush_i==1 at an edge loads a bubble (valid_o=0).
  - stall_o is forced to 0.
  - Flush takes priority over stall.
- valid_i==0 with no flush loads a bubble.
- A bubble never asserts reg_write_o, pc_write_o, is_load_o or is_store_o (all cleared).
- Priority at an edge: reset > flush > stall > load.

Optional Feature:
- Macro: DECODE_IMM_ROTATE_EN.
- When defined, the data-processing immediate is imm_o = ROR({24'b0, inst[7:0]}, 2*inst[11:8]).
- When undefined, imm_o = {24'b0, inst[7:0]} and inst[11:8] is ignored.
- Load/store and branch decoding are unaffected by the macro.

Test Plan:
- Reset: hold reset_n_i=0 for 2 cycles with valid_i=1, inst_i=0xE0821003 -> all outputs 0, stall_o=0. Release reset -> one cycle later valid_o=1, opcode_o=4, rn_o=2, rd_o=1, rm_o=3, reg_write_o=1.
- Branch: inst_i=0xEAFFFFFE, pc_i=0x20 -> is_branch_o=1, is_link_o=0, branch_target_o=0x20. Then inst_i=0xEB000004, pc_i=0x40 -> is_link_o=1, rd_o=14, branch_target_o=0x58.
- Load-use: LDR r1,[r2] (0xE5921000) then ADD r3,r1,r4 (0xE0813004) -> stall_o=1 for exactly 1 cycle, a bubble (valid_o=0) appears, then ADD is presented with valid_o=1. LDR followed by ADD r3,r5,r4 -> no stall.
- Flush over stall: recreate the load-use case and assert flush_i in the hazard cycle -> stall_o=0, next valid_o=0.
- PC write: MOV pc,r0 (0xE1A0F000) -> reg_write_o=1, pc_write_o=1. CMP r15,#0 -> reg_write_o=0, pc_write_o=0.
- Immediate: 0xE3A004FF (MOV r0,#0xFF ror 8) -> imm_o=0xFF000000 with DECODE_IMM_ROTATE_EN defined, 0x000000FF without it.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ARM decode stage of a 5-stage pipeline.
// Decodes data-processing, LDR/STR and B/BL into a registered ID/EX bundle,
// raises a combinational load-use stall back to fetch and honours the
// execute-stage flush.
// Optional feature: define DECODE_IMM_ROTATE_EN to apply the ARM rotate
// (ROR by 2*inst[11:8]) to the data-processing immediate; otherwise the
// immediate is the zero-extended inst[7:0].
//
// Handshake: an instruction is consumed at a rising edge when
// valid_i && !stall_o. While stall_o is high, fetch must hold inst_i/pc_i
// stable. valid_o qualifies the whole ID/EX bundle. When valid_o is low,
// reg_write_o, pc_write_o, is_load_o and is_store_o are also low.
module decode_stage #(
  parameter bit NOP_ON_NV = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [3:0]  cond_o,
  output logic [3:0]  opcode_o,
  output logic        set_flags_o,
  output logic [3:0]  rn_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  rm_o,
  output logic [31:0] imm_o,
  output logic        use_imm_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        is_branch_o,
  output logic        is_link_o,
  output logic        reg_write_o,
  output logic        pc_write_o,
  output logic [31:0] branch_target_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        set_flags;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] imm;
    logic        use_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_link;
    logic        reg_write;
    logic        pc_write;
    logic [31:0] branch_target;
  } id_ex_t;

  id_ex_t      q;
  id_ex_t      d;
  logic        q_valid;
  logic        nv_bubble;
  logic        is_dp, is_ls, is_br, dec_bubble;
  logic        reads_rn, reads_rm, reads_rd;
  logic        hazard;
  logic [31:0] dp_imm;
  logic [31:0] br_off;

  assign br_off = {{6{inst_i[23]}}, inst_i[23:0], 2'b00};

`ifdef DECODE_IMM_ROTATE_EN
  logic [4:0]  rot_amt;
  logic [63:0] rot_w;
  assign rot_amt = {inst_i[11:8], 1'b0};
  // Rotate right: shifting the doubled word keeps the bits that wrap around.
  assign rot_w   = {2{24'b0, inst_i[7:0]}} >> rot_amt;
  assign dp_imm  = rot_w[31:0];
`else
  assign dp_imm  = {24'b0, inst_i[7:0]};
`endif

  // Instruction class; cond==NV becomes a bubble only when NOP_ON_NV is set.
  always_comb begin
    nv_bubble  = NOP_ON_NV && (inst_i[31:28] == 4'hF);
    is_dp      = !nv_bubble && (inst_i[27:26] == 2'b00);
    is_ls      = !nv_bubble && (inst_i[27:26] == 2'b01);
    is_br      = !nv_bubble && (inst_i[27:26] == 2'b10) && inst_i[25];
    dec_bubble = !(is_dp || is_ls || is_br);
  end

  // Build the next ID/EX bundle from the incoming instruction.
  always_comb begin
    d               = '0;
    d.pc            = pc_i;
    d.cond          = inst_i[31:28];
    d.branch_target = pc_i + 32'd8 + br_off;
    if (is_dp) begin
      d.opcode    = inst_i[24:21];
      d.set_flags = inst_i[20];
      d.rn        = inst_i[19:16];
      d.rd        = inst_i[15:12];
      d.rm        = inst_i[3:0];
      d.use_imm   = inst_i[25];
      d.imm       = inst_i[25] ? dp_imm : 32'd0;
      // TST/TEQ/CMP/CMN (opcodes 8..11) only set flags.
      d.reg_write = (inst_i[24:23] != 2'b10);
    end else if (is_ls) begin
      d.rn        = inst_i[19:16];
      d.rd        = inst_i[15:12];
      d.rm        = inst_i[3:0];
      d.use_imm   = ~inst_i[25];
      d.imm       = {20'b0, inst_i[11:0]};
      d.is_load   = inst_i[20];
      d.is_store  = ~inst_i[20];
      d.reg_write = inst_i[20];
    end else if (is_br) begin
      d.is_branch = 1'b1;
      d.is_link   = inst_i[24];
      d.rd        = inst_i[24] ? 4'd14 : 4'd0;
      d.reg_write = inst_i[24];
      d.imm       = br_off;
    end
    d.pc_write = d.reg_write && (d.rd == 4'd15);
  end

  // Source registers the incoming instruction reads, compared with the load in ID/EX.
  always_comb begin
    reads_rn = 1'b0;
    reads_rm = 1'b0;
    reads_rd = 1'b0;
    if (is_dp) begin
      // MOV/MVN (13/15) ignore rn.
      reads_rn = !(inst_i[24] && inst_i[23] && inst_i[21]);
      reads_rm = ~inst_i[25];
    end else if (is_ls) begin
      reads_rn = 1'b1;
      reads_rm = inst_i[25];
      reads_rd = ~inst_i[20];
    end
    hazard = (reads_rn && (inst_i[19:16] == q.rd)) ||
             (reads_rm && (inst_i[3:0]   == q.rd)) ||
             (reads_rd && (inst_i[15:12] == q.rd));
    stall_o = reset_n_i && valid_i && q_valid && q.is_load && !flush_i && hazard;
  end

  // ID/EX register: reset > flush > stall > load; any bubble clears the side-effect flags.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (flush_i || stall_o || !valid_i || dec_bubble) begin
      q_valid     <= 1'b0;
      q.reg_write <= 1'b0;
      q.pc_write  <= 1'b0;
      q.is_load   <= 1'b0;
      q.is_store  <= 1'b0;
    end else begin
      q       <= d;
      q_valid <= 1'b1;
    end
  end

  assign valid_o         = q_valid;
  assign pc_o            = q.pc;
  assign cond_o          = q.cond;
  assign opcode_o        = q.opcode;
  assign set_flags_o     = q.set_flags;
  assign rn_o            = q.rn;
  assign rd_o            = q.rd;
  assign rm_o            = q.rm;
  assign imm_o           = q.imm;
  assign use_imm_o       = q.use_imm;
  assign is_load_o       = q.is_load;
  assign is_store_o      = q.is_store;
  assign is_branch_o     = q.is_branch;
  assign is_link_o       = q.is_link;
  assign reg_write_o     = q.reg_write;
  assign pc_write_o      = q.pc_write;
  assign branch_target_o = q.branch_target;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with an expected-bundle
// queue checked by a monitor whenever valid_o is high.
module tb_decode_stage;

  localparam int W = 124;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        set_flags;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] imm;
    logic        use_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_link;
    logic        reg_write;
    logic        pc_write;
    logic [31:0] branch_target;
  } bun_t;

  // {is_load, is_store, is_branch, is_link, reg_write, pc_write}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_RW    = 6'b000010;
  localparam logic [5:0] F_PCW   = 6'b000011;
  localparam logic [5:0] F_LOAD  = 6'b100010;
  localparam logic [5:0] F_STORE = 6'b010000;
  localparam logic [5:0] F_B     = 6'b001000;
  localparam logic [5:0] F_BL    = 6'b001110;

  // don't-care select: bit0 imm/use_imm, bit1 target, bit2 rn/rm, bit3 rd
  localparam logic [3:0] DC_T  = 4'b0010;
  localparam logic [3:0] DC_B  = 4'b1111;
  localparam logic [3:0] DC_BL = 4'b0111;

`ifdef DECODE_IMM_ROTATE_EN
  localparam logic [31:0] ROT_IMM = 32'hFF00_0000;
`else
  localparam logic [31:0] ROT_IMM = 32'h0000_00FF;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_n_i, valid_i, flush_i;
  logic [31:0] inst_i, pc_i;
  logic        stall_o, valid_o, set_flags_o, use_imm_o;
  logic        is_load_o, is_store_o, is_branch_o, is_link_o, reg_write_o, pc_write_o;
  logic [31:0] pc_o, imm_o, branch_target_o;
  logic [3:0]  cond_o, opcode_o, rn_o, rd_o, rm_o;

  decode_stage #(.NOP_ON_NV(1'b1)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .inst_i(inst_i),
    .pc_i(pc_i), .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .cond_o(cond_o), .opcode_o(opcode_o), .set_flags_o(set_flags_o),
    .rn_o(rn_o), .rd_o(rd_o), .rm_o(rm_o), .imm_o(imm_o), .use_imm_o(use_imm_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
    .is_link_o(is_link_o), .reg_write_o(reg_write_o), .pc_write_o(pc_write_o),
    .branch_target_o(branch_target_o)
  );

  bun_t act;
  assign act = {pc_o, cond_o, opcode_o, set_flags_o, rn_o, rd_o, rm_o, imm_o, use_imm_o,
                is_load_o, is_store_o, is_branch_o, is_link_o, reg_write_o, pc_write_o,
                branch_target_o};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_bit(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [3:0] opc, input logic sf,
                            input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                            input logic [31:0] imm, input logic use_imm, input logic [5:0] fl,
                            input logic [31:0] tgt, input logic [3:0] dc);
    bun_t e;
    bun_t m;
    e = {pc, 4'hE, opc, sf, rn, rd, rm, imm, use_imm, fl, tgt};
    m = '1;
    if (dc[0]) begin m.imm = '0; m.use_imm = 1'b0; end
    if (dc[1]) m.branch_target = '0;
    if (dc[2]) begin m.rn = '0; m.rm = '0; end
    if (dc[3]) m.rd = '0;
    exp_q.push_back(e & m);
    msk_q.push_back(m);
  endtask

  // monitor: compare every presented bundle against the head of the queue
  logic [W-1:0] mon_e, mon_m;
  always @(negedge clk_i) begin
    if (reset_n_i === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got bundle at pc %h, expected none", pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = msk_q.pop_front();
        check_vec("bundle", act & mon_m, mon_e);
      end
    end
  end

  // ---------------- driver tasks (start at posedge + #1) ----------------
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic exp_stall);
    valid_i = 1'b1; inst_i = inst; pc_i = pc; flush_i = 1'b0;
    @(negedge clk_i);
    check_bit("stall_o", stall_o, exp_stall);
    @(posedge clk_i); #1;
    if (exp_stall) begin
      @(negedge clk_i);
      check_bit("stall_release", stall_o, 1'b0);
      check_bit("stall_bubble", valid_o, 1'b0);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic flush_cycle(input logic [31:0] inst, input logic [31:0] pc);
    valid_i = 1'b1; inst_i = inst; pc_i = pc; flush_i = 1'b1;
    @(negedge clk_i);
    check_bit("flush_stall", stall_o, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    check_bit("flush_bubble", valid_o, 1'b0);
    @(posedge clk_i); #1;
  endtask

  task automatic send_bubble(input string name, input logic [31:0] inst, input logic [31:0] pc);
    valid_i = 1'b1; inst_i = inst; pc_i = pc; flush_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    check_bit(name, valid_o, 1'b0);
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; flush_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n_i = 1'b0; valid_i = 1'b1; flush_i = 1'b0;
    inst_i = 32'hE082_1003; pc_i = 32'h100;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_bit("reset_valid", valid_o, 1'b0);
    check_vec("reset_bundle", act, '0);
    check_bit("reset_stall", stall_o, 1'b0);
    // ADD r1,r2,r3 consumed at the release edge
    expect_out(32'h100, 4'd4, 1'b0, 4'd2, 4'd1, 4'd3, 32'h0, 1'b0, F_RW, 32'h0, DC_T);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    idle();

    // branches
    expect_out(32'h20, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, F_B, 32'h20, DC_B);
    send(32'hEAFF_FFFE, 32'h20, 1'b0);
    expect_out(32'h40, 4'd0, 1'b0, 4'd0, 4'd14, 4'd0, 32'h0, 1'b0, F_BL, 32'h58, DC_BL);
    send(32'hEB00_0004, 32'h40, 1'b0);
    idle();

    // load-use: LDR r1,[r2] then ADD r3,r1,r4 stalls once
    expect_out(32'h60, 4'd0, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0, 1'b1, F_LOAD, 32'h0, DC_T);
    send(32'hE592_1000, 32'h60, 1'b0);
    expect_out(32'h64, 4'd4, 1'b0, 4'd1, 4'd3, 4'd4, 32'h0, 1'b0, F_RW, 32'h0, DC_T);
    send(32'hE081_3004, 32'h64, 1'b1);
    idle();

    // LDR then ADD r3,r5,r4: independent, no stall
    expect_out(32'h68, 4'd0, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0, 1'b1, F_LOAD, 32'h0, DC_T);
    send(32'hE592_1000, 32'h68, 1'b0);
    expect_out(32'h6C, 4'd4, 1'b0, 4'd5, 4'd3, 4'd4, 32'h0, 1'b0, F_RW, 32'h0, DC_T);
    send(32'hE085_3004, 32'h6C, 1'b0);
    idle();

    // flush wins over the load-use stall
    expect_out(32'h70, 4'd0, 1'b0, 4'd2, 4'd1, 4'd0, 32'h0, 1'b1, F_LOAD, 32'h0, DC_T);
    send(32'hE592_1000, 32'h70, 1'b0);
    flush_cycle(32'hE081_3004, 32'h74);

    // MOV pc,r0 / CMP r15,#0 / MOV r0,#0xFF ror 8
    expect_out(32'h80, 4'd13, 1'b0, 4'd0, 4'd15, 4'd0, 32'h0, 1'b0, F_PCW, 32'h0, DC_T);
    send(32'hE1A0_F000, 32'h80, 1'b0);
    expect_out(32'h84, 4'd10, 1'b1, 4'd15, 4'd0, 4'd0, 32'h0, 1'b1, F_NONE, 32'h0, DC_T);
    send(32'hE35F_0000, 32'h84, 1'b0);
    expect_out(32'h88, 4'd13, 1'b0, 4'd0, 4'd0, 4'd15, ROT_IMM, 1'b1, F_RW, 32'h0, DC_T);
    send(32'hE3A0_04FF, 32'h88, 1'b0);
    idle();

    // store data register hazard: LDR r5,[r2] then STR r5,[r6]
    expect_out(32'h90, 4'd0, 1'b0, 4'd2, 4'd5, 4'd0, 32'h0, 1'b1, F_LOAD, 32'h0, DC_T);
    send(32'hE592_5000, 32'h90, 1'b0);
    expect_out(32'h94, 4'd0, 1'b0, 4'd6, 4'd5, 4'd0, 32'h0, 1'b1, F_STORE, 32'h0, DC_T);
    send(32'hE586_5000, 32'h94, 1'b1);

    // decoded bubbles: cond NV and class 11
    send_bubble("nv_bubble", 32'hF082_1003, 32'h98);
    send_bubble("class11_bubble", 32'hEE00_0000, 32'h9C);

    // LDR r0,[r1,r2] then MOV r7,#1 (rn field matches r0 but is not read)
    expect_out(32'hA0, 4'd0, 1'b0, 4'd1, 4'd0, 4'd2, 32'h2, 1'b0, F_LOAD, 32'h0, DC_T);
    send(32'hE791_0002, 32'hA0, 1'b0);
    expect_out(32'hA4, 4'd13, 1'b0, 4'd0, 4'd7, 4'd1, 32'h1, 1'b1, F_RW, 32'h0, DC_T);
    send(32'hE3A0_7001, 32'hA4, 1'b0);

    // load in ID/EX, dependent instruction but valid_i low: no stall
    expect_out(32'hA8, 4'd0, 1'b0, 4'd1, 4'd0, 4'd2, 32'h2, 1'b0, F_LOAD, 32'h0, DC_T);
    send(32'hE791_0002, 32'hA8, 1'b0);
    valid_i = 1'b0; inst_i = 32'hE1A0_7000; pc_i = 32'hAC;
    @(negedge clk_i);
    check_bit("stall_invalid", stall_o, 1'b0);
    @(posedge clk_i); #1;

    idle();
    idle();
    check_int("queue_empty", exp_q.size(), 0);
    report();
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    report();
    $finish;
  end

endmodule
